// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the SRAM-like split address/data bus bridges.
// The data-side and instruction-side bridges both use this package.
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bus_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Masks the core never emits fall back to a full word.
  function automatic logic [1:0] strb_to_size(input logic [3:0] strb);
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: strb_to_size = SIZE_BYTE;
      4'b0011, 4'b1100:                   strb_to_size = SIZE_HALF;
      default:                            strb_to_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// SRAM-like split address/data bus between the bridge (master) and the
// data-side arbiter or cache (slave).
interface dmem_sram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  bus_req;
  logic                  bus_wr;
  logic [1:0]            bus_size;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/dmem_sram_bridge.sv
// Turns the core's single-cycle data request into one SRAM-like bus
// transaction and stalls the core's M stage until the response returns.
module dmem_sram_bridge
  import dmem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] memen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                data_stall,
  input  logic                longest_stall,
  dmem_sram_bridge_if.master  bus
);

  bus_state_e          state_q;
  logic                req_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                wr_d;
  logic [1:0]          size_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W/8-1:0] wstrb_d;

  // Reads are always word-sized and word-aligned; the core extracts lanes.
  assign wr_d    = |memen;
  assign size_d  = wr_d ? strb_to_size(memen[3:0]) : SIZE_WORD;
  assign addr_d  = wr_d ? addr : {addr[ADDR_W-1:2], 2'b00};
  assign wstrb_d = wr_d ? memen : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_en) begin
            state_q <= ADDR;
            req_q   <= 1'b1;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata;
          end
        end
        // Once issued, the request runs to completion even if data_en drops.
        ADDR: begin
          if (bus.bus_addr_ok) begin
            req_q <= 1'b0;
            if (bus.bus_data_ok) begin
              state_q <= DONE;
              if (!wr_q) rdata_q <= bus.bus_rdata;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (bus.bus_data_ok) begin
            state_q <= DONE;
            if (!wr_q) rdata_q <= bus.bus_rdata;
          end
        end
        DONE: begin
          if (!longest_stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_stall    = ((state_q == IDLE) && data_en) ||
                         (state_q == ADDR) || (state_q == DATA);
  assign rdata         = rdata_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_size  = size_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Scoreboard bench for dmem_sram_bridge: the bench plays both the core and
// the bus slave on a fixed cycle schedule.
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [3:0]  memen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        data_stall;
  logic        longest_stall;

  dmem_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_en       (data_en),
    .memen         (memen),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .data_stall    (data_stall),
    .longest_stall (longest_stall),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] rdata_model = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_size(input logic [3:0] m);
    if (m == 4'b0000) return 2'd2;
    if ($countones(m) == 1) return 2'd0;
    if (m == 4'b0011 || m == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // Entered and left at posedge+1 of an IDLE cycle. data_dly < 0 means the
  // response comes in the same cycle as the address accept.
  task automatic txn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd,
                     input int addr_dly, input int data_dly, input logic [31:0] rd,
                     input int ls_extra, input bit flush, input bit b2b);
    exp_t e;
    exp_t got;
    int   stalls;
    int   reqs;
    int   exp_stalls;
    e.wr    = |m;
    e.size  = exp_size(m);
    e.addr  = e.wr ? a : {a[31:2], 2'b00};
    e.strb  = e.wr ? m : 4'b0000;
    e.wdata = wd;
    if (!e.wr) rdata_model = rd;
    e.rdata = rdata_model;
    sb_q.push_back(e);

    data_en = 1'b1; memen = m; addr = a; wdata = wd; longest_stall = 1'b1;
    #4;
    check_val("stall_c0", 32'(data_stall), 32'd1);
    check_val("req_c0", 32'(bus.bus_req), 32'd0);
    stalls = 1; reqs = 0;

    for (int i = 0; i <= addr_dly; i++) begin
      @(posedge clk); #1;
      if (flush) data_en = 1'b0;
      bus.bus_addr_ok = (i == addr_dly);
      bus.bus_data_ok = (i == addr_dly) && (data_dly < 0);
      bus.bus_rdata   = bus.bus_data_ok ? rd : ~rd;
      #4;
      if (i == 0) begin
        check_val("bus_wr", 32'(bus.bus_wr), 32'(sb_q[0].wr));
        check_val("bus_size", 32'(bus.bus_size), 32'(sb_q[0].size));
        check_val("bus_addr", bus.bus_addr, sb_q[0].addr);
        check_val("bus_wstrb", 32'(bus.bus_wstrb), 32'(sb_q[0].strb));
        check_val("bus_wdata", bus.bus_wdata, sb_q[0].wdata);
      end
      stalls += int'(data_stall);
      reqs   += int'(bus.bus_req);
    end

    if (data_dly >= 0) begin
      for (int j = 0; j <= data_dly; j++) begin
        @(posedge clk); #1;
        bus.bus_addr_ok = 1'b0;
        bus.bus_data_ok = (j == data_dly);
        bus.bus_rdata   = bus.bus_data_ok ? rd : ~rd;
        #4;
        check_val("req_in_data", 32'(bus.bus_req), 32'd0);
        stalls += int'(data_stall);
      end
    end

    // DONE: stray handshakes on the first cycle must be ignored.
    for (int k = 0; k <= ls_extra; k++) begin
      @(posedge clk); #1;
      bus.bus_addr_ok = (k == 0);
      bus.bus_data_ok = (k == 0);
      bus.bus_rdata   = 32'h5A5A_5A5A;
      longest_stall   = (k < ls_extra);
      #4;
      if (k == 0) begin
        got = sb_q.pop_front();
        check_val("rdata_done", rdata, got.rdata);
      end else begin
        check_val("rdata_hold", rdata, e.rdata);
      end
      check_val("stall_done", 32'(data_stall), 32'd0);
      check_val("req_done", 32'(bus.bus_req), 32'd0);
    end

    @(posedge clk); #1;
    bus.bus_addr_ok = 1'b0;
    bus.bus_data_ok = 1'b0;
    longest_stall   = 1'b0;
    exp_stalls = 2 + addr_dly + ((data_dly < 0) ? 0 : data_dly + 1);
    check_val("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check_val("req_cycles", 32'(reqs), 32'(addr_dly + 1));
    if (!b2b) begin
      data_en = 1'b0; memen = 4'b0000;
      #4;
      check_val("req_idle", 32'(bus.bus_req), 32'd0);
      check_val("stall_idle", 32'(data_stall), 32'd0);
      @(posedge clk); #1;
      #4;
      check_val("no_rereq", 32'(bus.bus_req), 32'd0);
      check_val("rdata_idle", rdata, rdata_model);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; data_en = 1'b0; memen = 4'b0000; addr = 32'h0; wdata = 32'h0;
    longest_stall = 1'b0;
    bus.bus_addr_ok = 1'b0; bus.bus_data_ok = 1'b0; bus.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4;
    check_val("rst_req", 32'(bus.bus_req), 32'd0);
    check_val("rst_wr", 32'(bus.bus_wr), 32'd0);
    check_val("rst_size", 32'(bus.bus_size), 32'd0);
    check_val("rst_addr", bus.bus_addr, 32'h0);
    check_val("rst_wstrb", 32'(bus.bus_wstrb), 32'd0);
    check_val("rst_wdata", bus.bus_wdata, 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_stall", 32'(data_stall), 32'd0);
    @(posedge clk); #1;

    txn(4'b0000, 32'h1000_0006, 32'h0,         0,  0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    txn(4'b1100, 32'h0000_0008, 32'hABCD_0000, 4,  0, 32'h1111_1111, 0, 1'b0, 1'b0);
    txn(4'b0000, 32'h0000_0020, 32'h0,         1,  2, 32'hCAFE_F00D, 3, 1'b0, 1'b0);
    txn(4'b0001, 32'h0000_0033, 32'h0000_00AA, 0,  0, 32'h2222_2222, 0, 1'b1, 1'b0);
    txn(4'b0000, 32'h0000_0044, 32'h0,         2, -1, 32'h0BAD_CAFE, 0, 1'b0, 1'b1);
    txn(4'b1111, 32'h0000_0050, 32'h1234_5678, 0,  1, 32'h3333_3333, 1, 1'b0, 1'b0);

    // Reset while waiting in DATA, then a stray late response.
    data_en = 1'b1; memen = 4'b0000; addr = 32'h0000_0040; longest_stall = 1'b1;
    @(posedge clk); #1;
    bus.bus_addr_ok = 1'b1;
    #4 check_val("rstdata_req", 32'(bus.bus_req), 32'd1);
    @(posedge clk); #1;
    bus.bus_addr_ok = 1'b0; rst = 1'b1; data_en = 1'b0;
    #4 check_val("rstdata_stall", 32'(data_stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; longest_stall = 1'b0;
    bus.bus_data_ok = 1'b1; bus.bus_rdata = 32'h1234_5678;
    #4;
    check_val("rstdata_req0", 32'(bus.bus_req), 32'd0);
    check_val("rstdata_wr", 32'(bus.bus_wr), 32'd0);
    check_val("rstdata_size", 32'(bus.bus_size), 32'd0);
    check_val("rstdata_addr", bus.bus_addr, 32'h0);
    check_val("rstdata_wstrb", 32'(bus.bus_wstrb), 32'd0);
    check_val("rstdata_wdata", bus.bus_wdata, 32'h0);
    check_val("rstdata_rdata", rdata, 32'h0);
    check_val("rstdata_stall0", 32'(data_stall), 32'd0);
    @(posedge clk); #1;
    bus.bus_data_ok = 1'b0;
    rdata_model = 32'h0;
    #4;
    check_val("stray_rdata", rdata, 32'h0);
    check_val("stray_req", 32'(bus.bus_req), 32'd0);
    @(posedge clk); #1;

    txn(4'b0011, 32'h0000_0062, 32'h0000_BEEF, 0, 0, 32'h4444_4444, 0, 1'b0, 1'b0);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Memory-side responder for the CPU core's data port. Accepts the core's single-cycle data request (enable, byte-enable mask, address, write data), converts it into one transaction on an SRAM-like split address/data bus, and holds the core in `data_stall` until the response arrives. It returns the captured read data on `rdata`. It sits between the core's data-port outputs and the data-side bus arbiter or cache.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes.

Ports:
- `clk` input 1. Single clock.
- `rst` input 1. Synchronous, active-high reset.
- `data_en` input 1. Core data request valid; already qualified by the M-stage flush.
- `memen` input `DATA_W/8`. Byte-enable mask; nonzero means write, zero means read.
- `addr` input `ADDR_W`. Core byte address.
- `wdata` input `DATA_W`. Core write data, already lane-aligned.
- `rdata` output `DATA_W`. Registered read data returned to the core.
- `data_stall` output 1. Core must hold its M stage.
- `longest_stall` input 1. Pipeline-wide stall, high while any stall source is active.
- `bus_req` output 1. Bus request.
- `bus_wr` output 1. 1 means write.
- `bus_size` output 2. Encoding: 0 = byte, 1 = half, 2 = word.
- `bus_addr` output `ADDR_W`. Bus address.
- `bus_wstrb` output `DATA_W/8`. Write byte strobes.
- `bus_wdata` output `DATA_W`. Write data.
- `bus_addr_ok` input 1. Request accepted; counts only when `bus_req` is high.
- `bus_data_ok` input 1. Response done, for both reads and writes.
- `bus_rdata` input `DATA_W`. Read data, valid with `bus_data_ok`.

## Operation
State machine states:
- IDLE: no transaction.
- ADDR: `bus_req` high, waiting for `bus_addr_ok`.
- DATA: waiting for `bus_data_ok`.
- DONE: result held until the pipeline moves.

Transitions:
- IDLE, `data_en`=1 → ADDR. Register all bus fields on this edge.
- ADDR, `bus_addr_ok`=1 and `bus_data_ok`=0 → DATA.
- ADDR, `bus_addr_ok`=1 and `bus_data_ok`=1 → DONE (accept and complete in the same cycle).
- DATA, `bus_data_ok`=1 → DONE.
- DONE, `longest_stall`=0 → IDLE. Otherwise stay in DONE.

Field rules:
- `bus_wr` = |`memen`.
- Writes: `bus_addr` = `addr`; `bus_wstrb` = `memen`.
- Write size from `memen`:
  - one bit set → 0;
  - 4'b0011 or 4'b1100 → 1;
  - 4'b1111 → 2;
  - any other mask → 2 (the core never produces one).
- Reads: `bus_size` = 2, `bus_addr` = {`addr[ADDR_W-1:2]`, 2'b00}, `bus_wstrb` = 0. The core does lane extraction.

Output rules:
- `bus_req` = (state == ADDR). Once raised, it stays high until `bus_addr_ok`; a request is never retracted.
- Once ADDR is entered the transaction always completes, even if `data_en` drops (late flush); the result is discarded by the core.
- `data_stall` = (IDLE & `data_en`) | ADDR | DATA. It is low in DONE, so the core advances as soon as `longest_stall` clears.
- `rdata` loads `bus_rdata` on `bus_data_ok` for reads only and keeps its value otherwise.
- In DONE, `data_en` (still asserted by the stalled core) must not start a new transaction.
- `bus_data_ok` or `bus_addr_ok` seen in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, `bus_req` 0, `bus_wr` 0, `bus_size` 0, `bus_addr` 0, `bus_wstrb` 0, `bus_wdata` 0, `rdata` 0. `data_stall` follows its equation (0 unless `data_en`).
- `rst` mid-transaction returns to IDLE next edge with `bus_req` 0. The outstanding transaction is abandoned; the bus side shares the same reset.
- Minimum latency with `bus_addr_ok` and `bus_data_ok` each asserted on the first eligible cycle:
  - request seen in cycle 0;
  - `bus_req` high in cycle 1;
  - DATA in cycle 2, response in cycle 2;
  - `rdata` valid and `data_stall` low in cycle 3.
  - Three stall cycles in total.
- Back-to-back: DONE→IDLE in cycle N; a new `data_en` in IDLE at cycle N+1 starts the next transaction. There is no dead cycle beyond DONE.
- Throughput is one transaction outstanding, never pipelined.

## Structure
- Shared package `dmem_bus_pkg` contains:
  - state enum (IDLE/ADDR/DATA/DONE);
  - size constants SIZE_BYTE/HALF/WORD;
  - function `strb_to_size`.
- The bridge itself is single-module, about 150 lines, with no sub-module. The package is reused by the instruction-side bridge.

## Test plan
- Read with `addr` 0x1000_0006, `memen` 0, bus returns 0xDEADBEEF at minimum latency → `bus_addr` 0x1000_0004, `bus_size` 2, `data_stall` high for 3 cycles, `rdata` 0xDEADBEEF in cycle 3.
- Write with `memen` 4'b1100, `addr` 0x8, `wdata` 0xABCD0000; `bus_addr_ok` delayed 4 cycles → `bus_req` held 5 cycles, `bus_size` 1, `bus_wstrb` 4'b1100, `rdata` unchanged.
- Read completes while `longest_stall` stays high 3 more cycles and `data_en` is held → stays in DONE, exactly one `bus_req` pulse-train, `rdata` stable.
- `data_en` drops in the cycle after the request (flush) → transaction still completes once; no second request.
- `rst` asserted while in DATA → next cycle IDLE, all outputs at reset values; a following `bus_data_ok` is ignored.
- `bus_addr_ok` and `bus_data_ok` in the same cycle → direct ADDR→DONE; `rdata` captured that edge.
